// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the sum_accumulator stage.
package sum_acc_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ACC_W  = 16;
  localparam int unsigned DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates a frame of {cout, sum} adder results into a wide total with a sticky
// overflow flag, handing the total downstream over a valid/ready handshake.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_count
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_frame_len;

  logic               w_in_ready;
  logic               w_accept;
  logic [ACC_W-1:0]   w_beat;
  logic [ACC_W:0]     w_sum;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_in_ready = (r_state != DONE);
  assign w_accept   = in_valid & w_in_ready & ~clear;
  assign w_beat     = ACC_W'({in_cout, in_sum});
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_beat};
  // A length of 0 wraps the counter back to 0 on the 2**CNT_W-th beat, so a plain
  // compare against the stored length also covers the full-frame case.
  assign w_cnt_inc  = r_count + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) w_state_nxt = (len == CNT_W'(1)) ? DONE : ACC;
        ACC:  if (w_accept && (w_cnt_inc == r_frame_len)) w_state_nxt = DONE;
        DONE: if (out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_frame_len <= '0;
    end else if (clear) begin
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      if (r_state == IDLE) begin
        r_acc       <= w_beat;
        r_ovf       <= 1'b0;
        r_count     <= CNT_W'(1);
        r_frame_len <= len;
      end else begin
        r_acc   <= w_sum[ACC_W-1:0];
        r_ovf   <= r_ovf | w_sum[ACC_W];
        r_count <= w_cnt_inc;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;
  assign out_count = r_count;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: two instances (16- and 10-bit totals) share stimulus
// and are checked against a frame-level reference model.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst, clear, in_valid, in_cout, out_ready;
  logic [3:0] len;
  logic [7:0] in_sum;

  logic       in_ready_a, out_valid_a, out_ovf_a;
  logic [15:0] out_acc_a;
  logic [3:0] out_count_a;
  logic       in_ready_b, out_valid_b, out_ovf_b;
  logic [9:0] out_acc_b;
  logic [3:0] out_count_b;

  sum_accumulator #(.DATA_W(8), .ACC_W(16), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .clear(clear), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_acc(out_acc_a), .out_ovf(out_ovf_a), .out_count(out_count_a)
  );

  sum_accumulator #(.DATA_W(8), .ACC_W(10), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .clear(clear), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_acc(out_acc_b), .out_ovf(out_ovf_b), .out_count(out_count_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned total;
    int unsigned beats;
  } frame_t;

  frame_t      sb[$];
  bit          m_pending = 1'b0;
  int unsigned m_beats   = 0;
  int unsigned m_target  = 0;
  int unsigned m_total   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole frames as plain integer sums; the only timing rules are that no
  // beat is taken while a total is waiting, and clear/rst abandon everything.
  always @(posedge clk or posedge rst) begin
    bit take, emit;
    if (rst) begin
      if (m_pending) sb.delete();
      m_pending = 1'b0;
      m_beats   = 0;
    end else begin
      take = in_valid && !clear && !m_pending;
      emit = m_pending && out_ready && !clear;
      if (clear) begin
        if (m_pending) sb.delete();
        m_pending = 1'b0;
        m_beats   = 0;
      end else if (emit) begin
        m_pending = 1'b0;
      end else if (take) begin
        if (m_beats == 0) begin
          m_target = (len == 4'd0) ? 16 : int'(len);
          m_total  = 0;
        end
        m_total += {in_cout, in_sum};
        m_beats++;
        if (m_beats == m_target) begin
          sb.push_back('{total: m_total, beats: m_beats});
          m_pending = 1'b1;
          m_beats   = 0;
        end
      end
    end
  end

  // Monitor: compares every presented total (stable while held) and pops on handshake.
  always @(negedge clk) begin
    frame_t e;
    if (!rst) begin
      chk("valid_a", out_valid_a, m_pending);
      chk("valid_b", out_valid_b, m_pending);
      chk("ready_a", in_ready_a, !m_pending);
      chk("ready_b", in_ready_b, !m_pending);
      if (m_pending && sb.size() > 0) begin
        e = sb[0];
        chk("acc16", out_acc_a, e.total % 65536);
        chk("ovf16", out_ovf_a, e.total > 65535);
        chk("acc10", out_acc_b, e.total % 1024);
        chk("ovf10", out_ovf_b, e.total > 1023);
        chk("count_a", out_count_a, e.beats % 16);
        chk("count_b", out_count_b, e.beats % 16);
        if (out_ready && !clear) void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input bit c, input logic [7:0] s, input logic [3:0] l,
                       input bit clr, input bit ordy);
    in_valid  = v;
    in_cout   = c;
    in_sum    = s;
    len       = l;
    clear     = clr;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_cout = 1'b0;
    in_sum = '0; len = 4'd1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Async reset in the middle of a frame.
    drive(1, 0, 8'h11, 4'd5, 0, 1);
    drive(1, 1, 8'h22, 4'd5, 0, 1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", out_valid_a, 0);
    chk("rst_ready", in_ready_a, 1);
    chk("rst_acc", out_acc_a, 0);
    chk("rst_ovf", out_ovf_a, 0);
    chk("rst_count", out_count_a, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Three-beat frame: 0x10 + 0x20 + 0x105.
    drive(1, 0, 8'h10, 4'd3, 0, 1);
    drive(1, 0, 8'h20, 4'd3, 0, 1);
    drive(1, 1, 8'h05, 4'd3, 0, 1);
    idle(2);

    // Sixteen beats of 511 via len=0.
    for (int i = 0; i < 16; i++) drive(1, 1, 8'hFF, 4'd0, 0, 1);
    idle(2);

    // Backpressure with in_valid held high.
    drive(1, 0, 8'h42, 4'd1, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 8'h55, 4'd1, 0, 0);
    drive(1, 0, 8'h55, 4'd1, 0, 1);
    drive(1, 0, 8'h66, 4'd1, 0, 1);
    idle(2);

    // Clear after two beats with a beat offered the same cycle.
    drive(1, 0, 8'h07, 4'd4, 0, 1);
    drive(1, 0, 8'h09, 4'd4, 0, 1);
    drive(1, 0, 8'h0B, 4'd4, 1, 1);
    chk("clr_acc", out_acc_a, 0);
    chk("clr_count", out_count_a, 0);
    drive(1, 0, 8'h01, 4'd2, 0, 1);
    drive(1, 0, 8'h02, 4'd2, 0, 1);
    idle(2);

    // Length change after the first beat is ignored.
    drive(1, 0, 8'h03, 4'd2, 0, 1);
    drive(1, 0, 8'h04, 4'd7, 0, 1);
    drive(0, 0, 8'h00, 4'd7, 0, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1), 8'($urandom),
            4'($urandom_range(0, 15) < 3 ? $urandom_range(0, 2) : $urandom),
            $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);
    idle(4);

    chk("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
